// File: rtl/led_matrix_pkg.sv
// Shared types and decode helpers for the 8x8 LED matrix scanner.
package led_matrix_pkg;
   localparam int NUM_COLS = 8;

   typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} scan_state_t;

   // Byte k holds the pixel byte of column k.
   typedef logic [NUM_COLS-1:0][7:0] frame_t;

   // Active-low one-hot: column i is selected by bit (7-i) low.
   function automatic logic [7:0] col_sel_n(input logic [2:0] idx);
      return ~(8'h80 >> idx);
   endfunction

   function automatic logic [7:0] bitrev8(input logic [7:0] d);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = d[7-i];
      return r;
   endfunction
endpackage

// File: rtl/led_matrix_scanner_scan_timer.sv
// Column period timer: cycle counter, BLANK/DRIVE phase and column index.
// Next-state values are exported so the top can register outputs without lag.
module scan_timer
   import led_matrix_pkg::*;
#(
   parameter int SCAN_DIV     = 8192,
   parameter int BLANK_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   output scan_state_t phase,
   output scan_state_t phase_nxt,
   output logic [2:0]  col_idx,
   output logic [2:0]  col_idx_nxt,
   output logic        col_first,
   output logic        frame_wrap
);
   localparam int CW = $clog2(SCAN_DIV);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          col_end;

   assign col_end    = (cnt == CW'(SCAN_DIV - 1));
   assign col_first  = (cnt == '0);
   assign frame_wrap = col_end && (col_idx == 3'(NUM_COLS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase   <= BLANK;
         cnt     <= '0;
         col_idx <= '0;
      end else begin
         phase   <= phase_nxt;
         cnt     <= cnt_nxt;
         col_idx <= col_idx_nxt;
      end
   end

   always_comb begin
      cnt_nxt     = col_end ? '0 : cnt + 1'b1;
      phase_nxt   = phase;
      col_idx_nxt = col_idx;
      case (phase)
         BLANK:   if (cnt_nxt == CW'(BLANK_CYCLES)) phase_nxt = DRIVE;
         DRIVE:   if (col_end) phase_nxt = BLANK;
         default: phase_nxt = BLANK;
      endcase
      if (col_end) col_idx_nxt = col_idx + 3'd1;
   end
endmodule

// File: rtl/led_matrix_scanner.sv
// 8x8 LED matrix scanner with tear-free shadow/active frame buffers.
// Optional LED_PWM_EN adds a 4-bit brightness input for per-column PWM dimming.
module led_matrix_scanner
   import led_matrix_pkg::*;
#(
   parameter int SCAN_DIV     = 8192,
   parameter int BLANK_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] frame_in,
   input  logic        frame_valid,
   output logic        frame_ready,
   output logic [7:0]  row,
   output logic [7:0]  col,
   output logic [2:0]  col_idx,
   output logic        frame_start
`ifdef LED_PWM_EN
   ,
   input  logic [3:0]  brightness
`endif
);
   scan_state_t phase, phase_nxt;
   logic [2:0]  col_idx_nxt;
   logic        col_first, frame_wrap;
   frame_t      shadow, active;
   logic        pending, transfer, pwm_on;

   scan_timer #(
      .SCAN_DIV    (SCAN_DIV),
      .BLANK_CYCLES(BLANK_CYCLES)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .phase      (phase),
      .phase_nxt  (phase_nxt),
      .col_idx    (col_idx),
      .col_idx_nxt(col_idx_nxt),
      .col_first  (col_first),
      .frame_wrap (frame_wrap)
   );

   assign frame_ready = !pending;
   assign transfer    = frame_valid && !pending;

   // Swap uses the pre-edge pending, so a transfer landing on the wrap waits a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow  <= '0;
         active  <= '0;
         pending <= 1'b0;
      end else begin
         if (frame_wrap && pending) active <= shadow;
         if (transfer) begin
            shadow  <= frame_in;
            pending <= 1'b1;
         end else if (frame_wrap) begin
            pending <= 1'b0;
         end
      end
   end

`ifdef LED_PWM_EN
   logic [3:0] pwm, pwm_nxt, bright_q, bright_eff;

   assign bright_eff = col_first ? brightness : bright_q;
   assign pwm_nxt    = (phase_nxt == DRIVE && phase == DRIVE) ? pwm + 4'd1 : 4'd0;
   assign pwm_on     = (pwm_nxt <= bright_eff);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm      <= '0;
         bright_q <= '0;
      end else begin
         pwm <= pwm_nxt;
         if (col_first) bright_q <= brightness;
      end
   end
`else
   assign pwm_on = 1'b1;
`endif

   // Active buffer never changes on an edge entering DRIVE, so its current value is exact.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row         <= 8'h00;
         col         <= 8'hFF;
         frame_start <= 1'b0;
      end else begin
         frame_start <= frame_wrap;
         if (phase_nxt == DRIVE) begin
            row <= pwm_on ? bitrev8(active[col_idx_nxt]) : 8'h00;
            col <= col_sel_n(col_idx_nxt);
         end else begin
            row <= 8'h00;
            col <= 8'hFF;
         end
      end
   end
endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner: cycle-indexed reference model feeds a queue, monitor compares.
module tb_led_matrix_scanner;
   localparam int SD = 16;
   localparam int BC = 4;
   localparam int FR = SD * 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] frame_in = '0;
   logic        frame_valid = 1'b0;
   logic        frame_ready;
   logic [7:0]  row, col;
   logic [2:0]  col_idx;
   logic        frame_start;
`ifdef LED_PWM_EN
   logic [3:0]  brightness = 4'hF;
`endif

   led_matrix_scanner #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_in   (frame_in),
      .frame_valid(frame_valid),
      .frame_ready(frame_ready),
      .row        (row),
      .col        (col),
      .col_idx    (col_idx),
      .frame_start(frame_start)
`ifdef LED_PWM_EN
      ,
      .brightness (brightness)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] row;
      logic [7:0] col;
      logic [2:0] idx;
      logic       fs;
      logic       rdy;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          m_n = 0;
   logic        m_pending = 1'b0;
   logic [63:0] m_shadow = '0;
   logic [63:0] m_act = '0;

   // Expected outputs m_n cycles after reset release.
   function automatic exp_t expect_now();
      exp_t       e;
      int         pos, c;
      logic [7:0] b;
      pos   = m_n % SD;
      c     = (m_n / SD) % 8;
      b     = m_act[c*8 +: 8];
      e.row = 8'h00;
      e.col = 8'hFF;
      if (pos >= BC) begin
         for (int k = 0; k < 8; k++) e.row[7-k] = b[k];
         e.col[7-c] = 1'b0;
      end
      e.idx = 3'(c);
      e.fs  = (m_n > 0) && (m_n % FR == 0);
      e.rdy = !m_pending;
      return e;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_n = 0; m_pending = 1'b0; m_shadow = '0; m_act = '0;
         exp_q.delete();
      end else begin
         automatic logic xfer = frame_valid && !m_pending;
         if ((m_n % FR == FR - 1) && m_pending) begin
            m_act     = m_shadow;
            m_pending = 1'b0;
         end
         if (xfer) begin
            m_shadow  = frame_in;
            m_pending = 1'b1;
         end
         m_n++;
         exp_q.push_back(expect_now());
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else if (exp_q.size() > 0) begin
         automatic exp_t e = exp_q.pop_front();
         total++;
         if ({row, col, col_idx, frame_start, frame_ready} !== e) begin
            bad++;
            $display("FAIL scan n=%0d got row=%h col=%h idx=%0d fs=%b rdy=%b want row=%h col=%h idx=%0d fs=%b rdy=%b",
                     m_n, row, col, col_idx, frame_start, frame_ready, e.row, e.col, e.idx, e.fs, e.rdy);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // Wait (at negedge) until no frame is pending and the frame position equals target.
   task automatic wait_for(input int target);
      int k;
      for (k = 0; k < 4 * FR; k++) begin
         @(negedge clk);
         if (!m_pending && (m_n % FR == target)) break;
      end
      total++;
      if (k == 4 * FR) begin
         bad++;
         $display("FAIL wait_for target=%0d got=timeout want=reached", target);
      end
   endtask

   task automatic offer_one(input logic [63:0] d);
      frame_in    = d;
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_row"}, 32'(row), 32'h00);
      check({tag, "_col"}, 32'(col), 32'hFF);
      check({tag, "_ready"}, 32'(frame_ready), 32'h1);
      check({tag, "_fs"}, 32'(frame_start), 32'h0);
      check({tag, "_idx"}, 32'(col_idx), 32'h0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 reset_checks("reset");
      @(negedge clk) rst = 1'b0;

      // Walking-bit frame: column k carries 1<<k.
      offer_one(64'h8040201008040201);
      repeat (3 * FR) @(negedge clk);

      // Continuous offers with changing data: backpressure until each boundary.
      for (int i = 0; i < 2 * FR + 20; i++) begin
         frame_in    = {$urandom, $urandom};
         frame_valid = 1'b1;
         @(negedge clk);
      end
      frame_valid = 1'b0;

      // Transfer exactly in the column-7 wrap cycle.
      wait_for(FR - 1);
      offer_one({$urandom, $urandom});
      repeat (2 * FR + 5) @(negedge clk);

      // Load during column 3; columns 4..7 must keep the old frame.
      wait_for(3 * SD + 5);
      offer_one({$urandom, $urandom});
      repeat (2 * FR) @(negedge clk);

      for (int i = 0; i < 3000; i++) begin
         frame_in    = {$urandom, $urandom};
         frame_valid = ($urandom_range(0, 31) == 0);
         @(negedge clk);
      end
      frame_valid = 1'b0;

      // Asynchronous reset in the middle of a DRIVE phase.
      begin
         int k;
         for (k = 0; k < 2 * SD; k++) begin
            @(negedge clk);
            if (m_n % SD == BC + 3) break;
         end
      end
      @(posedge clk);
      #3 rst = 1'b1;
      #1 reset_checks("midrst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2 * FR + 10) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
